mem_arb: RTL and testbench
==========================

Name: mem_arb

Overview:
- N-channel SRAM access arbiter and width adapter.
- Sits between several byte-addressed requesters (executor, packet parser, loader) and one word-wide synchronous SRAM.
- Arbitrates channels round-robin and converts byte address plus width into word address and byte-lane selects.
- Adds what the single-master combinational adapter lacks: unaligned accesses that cross a word boundary, split into two SRAM cycles.

Parameters:
- N_CH, 2, number of requester channels (1..8).
- ADDR_W, 32, byte address width.
- DATA_W, 32, SRAM word width; 32 or 64. BYTES = DATA_W/8; SEL_W = BYTES.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- req_ce_i  in  N_CH  per-channel request; held high until that channel's req_done_o.
- req_we_i  in  N_CH  per-channel write enable.
- req_addr_i  in  N_CH*ADDR_W  per-channel byte address.
- req_width_i  in  N_CH*4  per-channel access width in bytes (1, 2, 4; 8 only if DATA_W=64).
- req_data_i  in  N_CH*DATA_W  per-channel write data, right-aligned.
- req_data_o  out  DATA_W  shared read data; valid only while a req_done_o bit is high.
- req_done_o  out  N_CH  one-cycle completion pulse, at most one bit set.
- req_err_o  out  N_CH  pulse with done when width is invalid.
- mem_ce_o  out  1  SRAM chip enable.
- mem_we_o  out  1  SRAM write enable.
- mem_addr_o  out  ADDR_W  SRAM word index = byte addr >> log2(BYTES).
- mem_sel_o  out  SEL_W  byte-lane enables; lane k = bits [8k+7:8k].
- mem_data_o  out  DATA_W  SRAM write data, lane-shifted.
- mem_data_i  in  DATA_W  SRAM read data; valid the cycle after address is presented.

Behaviour:
- Reset (sync, active-high): state = IDLE, rr pointer = 0.
  - All outputs 0: mem_ce_o=0, mem_we_o=0, mem_sel_o=0, req_done_o=0, req_err_o=0, req_data_o=0.
  - mem_ce_o is gated with !rst, so no SRAM access is issued in the reset cycle.
  - Reset mid-operation aborts the access: no done, and any second half of a split write is not issued.
- Endianness: little-endian. off = addr mod BYTES; span = off + width > BYTES.
- State IDLE:
  - Grant the lowest channel index >= rr pointer with req_ce_i=1, wrapping.
  - Latch we/addr/width/data of the granted channel; set rr = grant+1 mod N_CH.
  - Valid width -> ACC0. Invalid width (0, 3, 5-7, >BYTES) -> DONE with err, no SRAM access.
- State ACC0:
  - mem_ce_o=1, mem_addr_o = word(addr).
  - mem_sel_o = lanes off..min(off+width, BYTES)-1.
  - mem_data_o = wdata << 8*off.
  - Next state: ACC1 if span, else DONE.
- State ACC1:
  - mem_addr_o = word(addr)+1, wrapping modulo 2^(ADDR_W-log2 BYTES).
  - mem_sel_o = lanes 0..off+width-BYTES-1; mem_data_o = wdata >> 8*(BYTES-off).
  - Capture the word0 read data. Next state: DONE.
- State DONE:
  - req_done_o[grant]=1 for one cycle.
  - Read data: assembled from the captured word0 and the live mem_data_i, shifted and zero-extended to DATA_W, masked to width.
  - Writes and errors: req_data_o=0. Next state: IDLE.
- Latency: request seen in IDLE cycle T.
  - Aligned or non-spanning: done at T+2.
  - Spanning: done at T+3.
  - Invalid width: done at T+1.
- Back-to-back: a channel still asserting req_ce_i in the cycle after its done is treated as a new request.
- Fairness: round-robin gives each waiting channel a grant within N_CH transactions.
- Simultaneous requests in IDLE: exactly one grant per IDLE cycle. Other requests stay pending, with no loss and no done.
- Changing req inputs of the granted channel after the grant has no effect, because the inputs are latched.

Optional Feature:
- MEM_ARB_FIXED_PRIO_EN
  - Defined: fixed priority, lowest channel index always wins in IDLE; rr pointer is removed.
  - Undefined (default): round-robin as described above.

Test Plan:
- Aligned read, DATA_W=32, ch0 reads addr 0x40 width 4, SRAM word 0x10 = 0x11223344 -> mem_addr_o=0x10, sel=4'b1111; done[0] at T+2, req_data_o=0x11223344.
- Unaligned split write, ch1 writes 0xAABBCCDD at addr 0x43 width 4 -> word 0x10 sel 4'b1000 data 0xDD000000, then word 0x11 sel 4'b0111 data 0x00AABBCC; done[1] at T+3. A read-back returns 0xAABBCCDD.
- Half-word read at addr 0x42, word = 0x11223344 -> sel 4'b1100, req_data_o=0x00001122.
- Round-robin: N_CH=3, all channels request continuously -> grant order 0,1,2,0,1,2, with no done overlap. With MEM_ARB_FIXED_PRIO_EN defined -> ch0 on every grant.
- Invalid width 3 on ch0 -> done[0] and err[0] at T+1, mem_ce_o never asserted, SRAM unchanged.
- Reset asserted in ACC0 of a spanning write -> second word untouched, no done; all outputs 0 the following cycle; state IDLE.

Source files
------------

// File: rtl/mem_arb.sv
// mem_arb: N-channel SRAM arbiter and byte-to-word adapter; unaligned accesses that cross a word are split into two SRAM cycles.
// Build option: define MEM_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module mem_arb #(
    parameter int N_CH   = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_CH-1:0]        req_ce_i,
    input  logic [N_CH-1:0]        req_we_i,
    input  logic [N_CH*ADDR_W-1:0] req_addr_i,
    input  logic [N_CH*4-1:0]      req_width_i,
    input  logic [N_CH*DATA_W-1:0] req_data_i,
    output logic [DATA_W-1:0]      req_data_o,
    output logic [N_CH-1:0]        req_done_o,
    output logic [N_CH-1:0]        req_err_o,
    output logic                   mem_ce_o,
    output logic                   mem_we_o,
    output logic [ADDR_W-1:0]      mem_addr_o,
    output logic [DATA_W/8-1:0]    mem_sel_o,
    output logic [DATA_W-1:0]      mem_data_o,
    input  logic [DATA_W-1:0]      mem_data_i,
    output logic [1:0]             dbg_state_o
);
    localparam int BYTES = DATA_W / 8;
    localparam int SEL_W = BYTES;
    localparam int LB    = $clog2(BYTES);
    localparam int WA_W  = ADDR_W - LB;
    localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;

    // Handshake: a channel holds req_ce_i (and its operands) until its one-cycle req_done_o; still high the cycle after done means a new request.
    typedef enum logic [1:0] {S_IDLE, S_ACC0, S_ACC1, S_DONE} state_t;
    state_t r_state, w_next;

    function automatic logic width_ok(input logic [3:0] w);
        return (w == 4'd1) || (w == 4'd2) || (w == 4'd4) || ((BYTES == 8) && (w == 4'd8));
    endfunction

    logic [CH_W-1:0]   w_grant;
    logic              w_any;
    logic [CH_W-1:0]   r_grant;
    logic              r_we;
    logic              r_err;
    logic [ADDR_W-1:0] r_addr;
    logic [3:0]        r_width;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_word0;
`ifndef MEM_ARB_FIXED_PRIO_EN
    logic [CH_W-1:0]   r_rr;
`endif

    always_comb begin
        int              idx;
        logic [CH_W-1:0] cand;
        idx     = 0;
        cand    = '0;
        w_any   = 1'b0;
        w_grant = '0;
        for (int i = 0; i < N_CH; i++) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
            idx = i;
`else
            idx = int'(r_rr) + i;
            if (idx >= N_CH) idx = idx - N_CH;
`endif
            cand = CH_W'(idx);
            if (!w_any && req_ce_i[cand]) begin
                w_any   = 1'b1;
                w_grant = cand;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_grant <= '0;
            r_we    <= 1'b0;
            r_err   <= 1'b0;
            r_addr  <= '0;
            r_width <= '0;
            r_wdata <= '0;
            r_word0 <= '0;
`ifndef MEM_ARB_FIXED_PRIO_EN
            r_rr    <= '0;
`endif
        end else begin
            if (r_state == S_IDLE && w_any) begin
                r_grant <= w_grant;
                r_we    <= req_we_i[w_grant];
                r_addr  <= req_addr_i[int'(w_grant)*ADDR_W +: ADDR_W];
                r_width <= req_width_i[int'(w_grant)*4 +: 4];
                r_wdata <= req_data_i[int'(w_grant)*DATA_W +: DATA_W];
                r_err   <= !width_ok(req_width_i[int'(w_grant)*4 +: 4]);
`ifndef MEM_ARB_FIXED_PRIO_EN
                if (int'(w_grant) == N_CH - 1) r_rr <= '0;
                else                           r_rr <= w_grant + 1'b1;
`endif
            end
            if (r_state == S_ACC1) r_word0 <= mem_data_i;
        end
    end

    // Lane and data vectors are computed double-width; the upper half is the second word of a split access.
    logic [LB-1:0]       w_off;
    logic                w_span;
    logic [SEL_W-1:0]    w_width_lanes;
    logic [2*SEL_W-1:0]  w_lanes;
    logic [2*DATA_W-1:0] w_wr_wide;
    logic [WA_W-1:0]     w_word0;
    logic [WA_W-1:0]     w_word1;
    logic [DATA_W-1:0]   w_rd_lo;
    logic [DATA_W-1:0]   w_rd_hi;
    logic [DATA_W-1:0]   w_rd_shift;
    logic [DATA_W-1:0]   w_rd_mask;

    assign w_off         = r_addr[LB-1:0];
    assign w_span        = (int'(w_off) + int'(r_width)) > BYTES;
    assign w_width_lanes = SEL_W'((16'd1 << r_width) - 16'd1);
    assign w_lanes       = {{SEL_W{1'b0}}, w_width_lanes} << w_off;
    assign w_wr_wide     = {{DATA_W{1'b0}}, r_wdata} << {w_off, 3'b000};
    assign w_word0       = r_addr[ADDR_W-1:LB];
    assign w_word1       = w_word0 + 1'b1;
    assign w_rd_lo       = w_span ? r_word0 : mem_data_i;
    assign w_rd_hi       = w_span ? mem_data_i : '0;
    assign w_rd_shift    = DATA_W'({w_rd_hi, w_rd_lo} >> {w_off, 3'b000});

    always_comb begin
        w_rd_mask = '0;
        for (int k = 0; k < SEL_W; k++) w_rd_mask[8*k +: 8] = {8{w_width_lanes[k]}};
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next     = r_state;
        mem_ce_o   = 1'b0;
        mem_we_o   = 1'b0;
        mem_addr_o = '0;
        mem_sel_o  = '0;
        mem_data_o = '0;
        req_done_o = '0;
        req_err_o  = '0;
        req_data_o = '0;
        case (r_state)
            S_IDLE: begin
                if (w_any) w_next = width_ok(req_width_i[int'(w_grant)*4 +: 4]) ? S_ACC0 : S_DONE;
            end
            S_ACC0: begin
                mem_ce_o   = 1'b1;
                mem_we_o   = r_we;
                mem_addr_o = ADDR_W'(w_word0);
                mem_sel_o  = w_lanes[SEL_W-1:0];
                mem_data_o = r_we ? w_wr_wide[DATA_W-1:0] : '0;
                w_next     = w_span ? S_ACC1 : S_DONE;
            end
            S_ACC1: begin
                mem_ce_o   = 1'b1;
                mem_we_o   = r_we;
                mem_addr_o = ADDR_W'(w_word1);
                mem_sel_o  = w_lanes[2*SEL_W-1:SEL_W];
                mem_data_o = r_we ? w_wr_wide[2*DATA_W-1:DATA_W] : '0;
                w_next     = S_DONE;
            end
            S_DONE: begin
                req_done_o[r_grant] = 1'b1;
                req_err_o[r_grant]  = r_err;
                if (!r_we && !r_err) req_data_o = w_rd_shift & w_rd_mask;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
        // Reset cycle: nothing leaves the block, so an aborted access never reaches the SRAM.
        if (rst) begin
            mem_ce_o   = 1'b0;
            mem_we_o   = 1'b0;
            mem_addr_o = '0;
            mem_sel_o  = '0;
            mem_data_o = '0;
            req_done_o = '0;
            req_err_o  = '0;
            req_data_o = '0;
        end
    end

    assign dbg_state_o = r_state;
endmodule

// File: tb/tb_mem_arb.sv
// Directed bench for mem_arb (N_CH=3, DATA_W=32) with a behavioural synchronous SRAM; honours MEM_ARB_FIXED_PRIO_EN.
module tb_mem_arb;
    localparam int N_CH   = 3;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [N_CH-1:0]        req_ce_i;
    logic [N_CH-1:0]        req_we_i;
    logic [N_CH*ADDR_W-1:0] req_addr_i;
    logic [N_CH*4-1:0]      req_width_i;
    logic [N_CH*DATA_W-1:0] req_data_i;
    logic [DATA_W-1:0]      req_data_o;
    logic [N_CH-1:0]        req_done_o;
    logic [N_CH-1:0]        req_err_o;
    logic                   mem_ce_o;
    logic                   mem_we_o;
    logic [ADDR_W-1:0]      mem_addr_o;
    logic [3:0]             mem_sel_o;
    logic [DATA_W-1:0]      mem_data_o;
    logic [DATA_W-1:0]      mem_data_i;
    logic [1:0]             dbg_state_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_arb #(.N_CH(N_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst),
        .req_ce_i(req_ce_i), .req_we_i(req_we_i), .req_addr_i(req_addr_i),
        .req_width_i(req_width_i), .req_data_i(req_data_i),
        .req_data_o(req_data_o), .req_done_o(req_done_o), .req_err_o(req_err_o),
        .mem_ce_o(mem_ce_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_sel_o(mem_sel_o), .mem_data_o(mem_data_o), .mem_data_i(mem_data_i),
        .dbg_state_o(dbg_state_o)
    );

    // Synchronous SRAM: read data appears the cycle after the address; bd_* is a backdoor preload port.
    logic [31:0] sram [256];
    logic        bd_en;
    logic [7:0]  bd_addr;
    logic [31:0] bd_data;
    int          ce_count = 0;

    always @(posedge clk) begin
        if (bd_en) sram[bd_addr] <= bd_data;
        if (mem_ce_o) begin
            ce_count <= ce_count + 1;
            if (mem_we_o)
                for (int k = 0; k < 4; k++)
                    if (mem_sel_o[k]) sram[mem_addr_o[7:0]][8*k +: 8] <= mem_data_o[8*k +: 8];
            mem_data_i <= sram[mem_addr_o[7:0]];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int ch, input logic we, input logic [31:0] addr,
                         input logic [3:0] w, input logic [31:0] d);
        req_we_i[ch]             = we;
        req_addr_i[ch*32 +: 32]  = addr;
        req_width_i[ch*4 +: 4]   = w;
        req_data_i[ch*32 +: 32]  = d;
        req_ce_i[ch]             = 1'b1;
    endtask

    task automatic poke(input logic [7:0] a, input logic [31:0] d);
        bd_en   = 1'b1;
        bd_addr = a;
        bd_data = d;
        tick();
        bd_en   = 1'b0;
    endtask

    logic [1:0]  exp_q[$];
    logic [31:0] rr_word [3];

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          c0;
        int          waited;
        logic [1:0]  exp_ch;

        rst = 1'b1;
        req_ce_i = '0; req_we_i = '0; req_addr_i = '0; req_width_i = '0; req_data_i = '0;
        bd_en = 1'b0; bd_addr = '0; bd_data = '0;
        rr_word[0] = 32'hA0A0A0A0; rr_word[1] = 32'hB1B1B1B1; rr_word[2] = 32'hC2C2C2C2;

        // Reset: a request presented during reset must not reach the SRAM.
        drive(0, 1'b0, 32'h40, 4'd4, 32'h0);
        tick();
        chk("rst_ce", mem_ce_o, 0);
        chk("rst_done", req_done_o, 0);
        chk("rst_sel", mem_sel_o, 0);
        chk("rst_data", req_data_o, 0);
        chk("rst_state", dbg_state_o, 0);
        req_ce_i = '0;
        poke(8'h10, 32'h11223344); poke(8'h11, 32'h0); poke(8'h12, 32'h55667788);
        poke(8'h14, rr_word[0]); poke(8'h15, rr_word[1]); poke(8'h16, rr_word[2]);
        poke(8'h18, 32'h0); poke(8'h1C, 32'h0); poke(8'h1D, 32'h0);
        rst = 1'b0;

        // Aligned read ch0, 0x40 width 4.
        drive(0, 1'b0, 32'h40, 4'd4, 32'h0);
        tick();
        chk("al_state", dbg_state_o, 1);
        chk("al_ce", mem_ce_o, 1);
        chk("al_we", mem_we_o, 0);
        chk("al_addr", mem_addr_o, 32'h10);
        chk("al_sel", mem_sel_o, 4'b1111);
        chk("al_done_early", req_done_o, 0);
        tick();
        chk("al_done", req_done_o, 3'b001);
        chk("al_err", req_err_o, 0);
        chk("al_data", req_data_o, 32'h11223344);
        req_ce_i[0] = 1'b0;
        tick();
        chk("al_idle_done", req_done_o, 0);

        // Split write ch1, 0xAABBCCDD at 0x43.
        drive(1, 1'b1, 32'h43, 4'd4, 32'hAABBCCDD);
        tick();
        chk("sw_addr0", mem_addr_o, 32'h10);
        chk("sw_sel0", mem_sel_o, 4'b1000);
        chk("sw_data0", mem_data_o, 32'hDD000000);
        chk("sw_we0", mem_we_o, 1);
        tick();
        chk("sw_state1", dbg_state_o, 2);
        chk("sw_addr1", mem_addr_o, 32'h11);
        chk("sw_sel1", mem_sel_o, 4'b0111);
        chk("sw_data1", mem_data_o, 32'h00AABBCC);
        chk("sw_done_early", req_done_o, 0);
        tick();
        chk("sw_done", req_done_o, 3'b010);
        chk("sw_rdata", req_data_o, 0);
        req_ce_i[1] = 1'b0;
        tick();
        chk("sw_mem10", sram[8'h10], 32'hDD223344);
        chk("sw_mem11", sram[8'h11], 32'h00AABBCC);

        // Read-back of the split write on ch2.
        drive(2, 1'b0, 32'h43, 4'd4, 32'h0);
        tick();
        chk("rb_sel0", mem_sel_o, 4'b1000);
        tick();
        chk("rb_addr1", mem_addr_o, 32'h11);
        tick();
        chk("rb_done", req_done_o, 3'b100);
        chk("rb_data", req_data_o, 32'hAABBCCDD);
        req_ce_i[2] = 1'b0;
        tick();

        // Half-word read at 0x42.
        poke(8'h10, 32'h11223344);
        drive(0, 1'b0, 32'h42, 4'd2, 32'h0);
        tick();
        chk("hw_sel", mem_sel_o, 4'b1100);
        tick();
        chk("hw_done", req_done_o, 3'b001);
        chk("hw_data", req_data_o, 32'h00001122);
        req_ce_i[0] = 1'b0;
        tick();

        // Invalid width 3: immediate done+err, no SRAM traffic.
        c0 = ce_count;
        drive(0, 1'b1, 32'h44, 4'd3, 32'hFFFFFFFF);
        tick();
        chk("inv_done", req_done_o, 3'b001);
        chk("inv_err", req_err_o, 3'b001);
        chk("inv_ce", mem_ce_o, 0);
        chk("inv_data", req_data_o, 0);
        req_ce_i[0] = 1'b0;
        tick();
        chk("inv_no_ce", ce_count, c0);
        chk("inv_mem11", sram[8'h11], 32'h00AABBCC);

        // Spanning half-word read at 0x47.
        drive(1, 1'b0, 32'h47, 4'd2, 32'h0);
        tick();
        chk("sh_addr0", mem_addr_o, 32'h11);
        chk("sh_sel0", mem_sel_o, 4'b1000);
        tick();
        chk("sh_addr1", mem_addr_o, 32'h12);
        chk("sh_sel1", mem_sel_o, 4'b0001);
        tick();
        chk("sh_done", req_done_o, 3'b010);
        chk("sh_data", req_data_o, 32'h00008800);
        req_ce_i[1] = 1'b0;
        tick();

        // Operands changed after the grant must be ignored.
        drive(2, 1'b1, 32'h60, 4'd4, 32'h12345678);
        tick();
        req_addr_i[2*32 +: 32] = 32'h64;
        req_data_i[2*32 +: 32] = 32'hDEADBEEF;
        req_width_i[2*4 +: 4]  = 4'd1;
        req_we_i[2]            = 1'b0;
        #1;
        chk("lat_addr", mem_addr_o, 32'h18);
        chk("lat_data", mem_data_o, 32'h12345678);
        chk("lat_sel", mem_sel_o, 4'b1111);
        chk("lat_we", mem_we_o, 1);
        tick();
        chk("lat_done", req_done_o, 3'b100);
        req_ce_i[2] = 1'b0;
        tick();
        chk("lat_mem18", sram[8'h18], 32'h12345678);

        // Arbitration with all three channels requesting continuously, pointer reset to 0.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int n = 0; n < 6; n++) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
            exp_q.push_back(2'd0);
`else
            exp_q.push_back(2'(n % 3));
`endif
        end
        drive(0, 1'b0, 32'h50, 4'd4, 32'h0);
        drive(1, 1'b0, 32'h54, 4'd4, 32'h0);
        drive(2, 1'b0, 32'h58, 4'd4, 32'h0);
        for (int n = 0; n < 6; n++) begin
            waited = 0;
            while (req_done_o == '0 && waited < 10) begin
                tick();
                waited++;
            end
            exp_ch = exp_q.pop_front();
            chk("rr_wait", (waited < 10), 1);
            chk("rr_grant", req_done_o, 64'(1) << exp_ch);
            chk("rr_data", req_data_o, rr_word[exp_ch]);
            if (n == 5) req_ce_i = '0;
            tick();
        end
        tick();
        chk("rr_quiet", req_done_o, 0);
        chk("rr_idle", dbg_state_o, 0);

        // Reset during ACC0 of a spanning write aborts it.
        drive(2, 1'b1, 32'h71, 4'd4, 32'hCAFEBABE);
        tick();
        chk("ra_ce", mem_ce_o, 1);
        chk("ra_addr", mem_addr_o, 32'h1C);
        chk("ra_sel", mem_sel_o, 4'b1110);
        rst = 1'b1;
        req_ce_i = '0;
        #1;
        chk("ra_gate_ce", mem_ce_o, 0);
        chk("ra_gate_sel", mem_sel_o, 0);
        tick();
        rst = 1'b0;
        #1;
        chk("ra_state", dbg_state_o, 0);
        chk("ra_ce_after", mem_ce_o, 0);
        chk("ra_done_after", req_done_o, 0);
        chk("ra_data_after", req_data_o, 0);
        tick();
        chk("ra_done_later", req_done_o, 0);
        tick();
        chk("ra_mem1d", sram[8'h1D], 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
